// File: rtl/mem_load_unit_pkg.sv
// Shared definitions for the load unit: op encodings, FSM states, defaults.
package mem_load_unit_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned OP_W            = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4
    } load_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } load_state_e;

    // True when the op is legal and the address is naturally aligned for it.
    function automatic logic load_legal(input logic [OP_W-1:0] op, input logic [1:0] lo);
        case (op)
            OP_LB, OP_LBU: return 1'b1;
            OP_LH, OP_LHU: return !lo[0];
            OP_LW:         return (lo == 2'b00);
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_unit_align_ext.sv
// Byte/half lane select from a little-endian word plus sign/zero extension.
module load_align_ext
    import mem_load_unit_pkg::*;
(
    input  logic [31:0]     word,
    input  logic [1:0]      addr,
    input  logic [OP_W-1:0] op,
    output logic [31:0]     result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{addr, 3'b111} -: 8];
        lane_h = addr[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   result = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  result = {24'h0, lane_b};
            OP_LH:   result = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  result = {16'h0, lane_h};
            OP_LW:   result = word;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Single-outstanding load unit: issues one aligned word read, waits with a
// timeout, then returns the lane-selected, extended result to writeback.
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_addr,
    input  logic [4:0]      req_rd,
    output logic            mem_re,
    output logic [31:0]     mem_addr,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            rsp_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    load_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [1:0]      lo_q, lo_d;
    logic [4:0]      rd_q, rd_d;

    logic            req_ready_d, mem_re_d, rsp_valid_d, rsp_err_d;
    logic [31:0]     mem_addr_d, rsp_data_d;
    logic [4:0]      rsp_rd_d;
    logic [31:0]     aligned_c;

    load_align_ext u_align (
        .word   (mem_rdata),
        .addr   (lo_q),
        .op     (op_q),
        .result (aligned_c)
    );

    // Next-state and next-output logic; every registered output has a _d here.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        lo_d        = lo_q;
        rd_d        = rd_q;
        mem_re_d    = 1'b0;
        mem_addr_d  = 32'h0;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_rd_d    = rsp_rd;
        rsp_err_d   = rsp_err;

        case (state_q)
            ST_IDLE: begin
                rsp_valid_d = 1'b0;
                if (req_valid) begin
                    op_d = req_op;
                    lo_d = req_addr[1:0];
                    rd_d = req_rd;
                    if (load_legal(req_op, req_addr[1:0])) begin
                        state_d    = ST_ISSUE;
                        mem_re_d   = 1'b1;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 32'h0;
                        rsp_rd_d    = req_rd;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d    = ST_WAIT;
                cnt_d      = '0;
                mem_addr_d = mem_addr;
            end
            ST_WAIT: begin
                // Data arriving on the final timeout cycle still wins.
                if (mem_rvalid) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = aligned_c;
                    rsp_rd_d    = rd_q;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'h0;
                    rsp_rd_d    = rd_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_addr_d = mem_addr;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            lo_q      <= '0;
            rd_q      <= '0;
            req_ready <= 1'b1;
            mem_re    <= 1'b0;
            mem_addr  <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_rd    <= 5'h0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            lo_q      <= lo_d;
            rd_q      <= rd_d;
            req_ready <= req_ready_d;
            mem_re    <= mem_re_d;
            mem_addr  <= mem_addr_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_rd    <= rsp_rd_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed self-checking bench for mem_load_unit.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [4:0]  req_rd;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_load_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_rd     (req_rd),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, acts as memory (rvalid on WAIT cycle index lat, -1 = never),
    // and returns once rsp_valid is seen. edges counts clock edges after the accept edge.
    task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                            input int lat, input logic [31:0] rdata,
                            output logic saw_re, output logic [31:0] re_addr,
                            output logic [31:0] wait_addr, output int re_count, output int edges);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
        edges     = 0;
        saw_re    = mem_re;
        re_addr   = mem_addr;
        wait_addr = 32'h0;
        re_count  = mem_re ? 1 : 0;
        for (int k = 0; k < 40 && !rsp_valid; k++) begin
            mem_rvalid = (k == lat + 1);
            mem_rdata  = rdata;
            tick();
            edges++;
            if (mem_re) re_count++;
            if (k == 0) wait_addr = mem_addr;
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h0; req_rd = 5'd1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; rsp_ready = 1'b1;
        tick(); tick();
        tests_run++;
        if ({req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b re=%b maddr=%h v=%b d=%h rd=%h e=%b, expected rdy=1 others 0",
                     req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err);
        end
        req_valid = 1'b0; mem_rvalid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lb();
        logic saw; logic [31:0] ra, wa; int rc, ed;
        run_load(3'd0, 32'h0000_0103, 5'd7, 0, 32'h80FF_1234, saw, ra, wa, rc, ed);
        tests_run++;
        if (ra !== 32'h0000_0100 || wa !== 32'h0000_0100) begin
            tests_failed++; $display("FAIL lb_mem_addr: got issue=%h wait=%h expected 00000100", ra, wa);
        end
        tests_run++;
        if (!saw || rc != 1) begin
            tests_failed++; $display("FAIL lb_mem_re_pulse: got saw=%b count=%0d expected 1 and 1", saw, rc);
        end
        tests_run++;
        if (ed != 2) begin
            tests_failed++; $display("FAIL lb_latency: got %0d edges expected 2", ed);
        end
        tests_run++;
        if (rsp_data !== 32'hFFFF_FF80 || rsp_err !== 1'b0 || rsp_rd !== 5'd7) begin
            tests_failed++; $display("FAIL lb_result: got d=%h e=%b rd=%0d expected ffffff80 0 7", rsp_data, rsp_err, rsp_rd);
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0) begin
            tests_failed++; $display("FAIL lb_return_idle: got v=%b rdy=%b maddr=%h expected 0 1 0", rsp_valid, req_ready, mem_addr);
        end
    endtask

    task automatic test_half();
        logic saw; logic [31:0] ra, wa; int rc, ed;
        run_load(3'd3, 32'h0000_0202, 5'd3, 2, 32'h9ABC_0001, saw, ra, wa, rc, ed);
        tests_run++;
        if (rsp_data !== 32'h0000_9ABC || rsp_err !== 1'b0 || ra !== 32'h0000_0200 || ed != 4) begin
            tests_failed++; $display("FAIL lhu_result: got d=%h e=%b maddr=%h edges=%0d expected 00009abc 0 00000200 4", rsp_data, rsp_err, ra, ed);
        end
        tick();
        run_load(3'd2, 32'h0000_0202, 5'd4, 0, 32'h9ABC_0001, saw, ra, wa, rc, ed);
        tests_run++;
        if (rsp_data !== 32'hFFFF_9ABC || rsp_err !== 1'b0 || rsp_rd !== 5'd4) begin
            tests_failed++; $display("FAIL lh_result: got d=%h e=%b rd=%0d expected ffff9abc 0 4", rsp_data, rsp_err, rsp_rd);
        end
        tick();
        run_load(3'd1, 32'h0000_0301, 5'd9, 0, 32'h1122_C344, saw, ra, wa, rc, ed);
        tests_run++;
        if (rsp_data !== 32'h0000_00C3) begin
            tests_failed++; $display("FAIL lbu_result: got d=%h expected 000000c3", rsp_data);
        end
        tick();
    endtask

    task automatic test_errors();
        logic saw; logic [31:0] ra, wa; int rc, ed;
        logic [2:0]  ops   [3] = '{3'd4, 3'd6, 3'd2};
        logic [31:0] addrs [3] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0105};
        for (int i = 0; i < 3; i++) begin
            run_load(ops[i], addrs[i], 5'(i + 20), 0, 32'hFFFF_FFFF, saw, ra, wa, rc, ed);
            tests_run++;
            if (saw !== 1'b0 || rc != 0 || ed != 0 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_rd !== 5'(i + 20)) begin
                tests_failed++;
                $display("FAIL err_case%0d: got re=%b edges=%0d e=%b d=%h rd=%0d expected re=0 edges=0 e=1 d=0 rd=%0d",
                         i, saw, ed, rsp_err, rsp_data, rsp_rd, i + 20);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic saw; logic [31:0] ra, wa; int rc, ed;
        run_load(3'd4, 32'h0000_0400, 5'd11, -1, 32'h1234_5678, saw, ra, wa, rc, ed);
        tests_run++;
        if (ed != 17 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_rd !== 5'd11) begin
            tests_failed++; $display("FAIL timeout: got edges=%0d e=%b d=%h rd=%0d expected 17 1 0 11", ed, rsp_err, rsp_data, rsp_rd);
        end
        tick();
        run_load(3'd4, 32'h0000_0404, 5'd12, 15, 32'h1234_5678, saw, ra, wa, rc, ed);
        tests_run++;
        if (ed != 17 || rsp_err !== 1'b0 || rsp_data !== 32'h1234_5678) begin
            tests_failed++; $display("FAIL timeout_data_wins: got edges=%0d e=%b d=%h expected 17 0 12345678", ed, rsp_err, rsp_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic saw; logic [31:0] ra, wa; int rc, ed;
        int bad = 0;
        rsp_ready = 1'b0;
        run_load(3'd4, 32'h0000_0800, 5'd17, 1, 32'hDEAD_BEEF, saw, ra, wa, rc, ed);
        req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h0000_0900; req_rd = 5'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || rsp_rd !== 5'd17 ||
                rsp_err !== 1'b0 || req_ready !== 1'b0 || mem_re !== 1'b0) bad++;
        end
        req_valid = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
        end
        rsp_ready = 1'b1;
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL backpressure_release: got v=%b rdy=%b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic saw; logic [31:0] ra, wa; int rc, ed;
        run_load(3'd4, 32'h0000_0A00, 5'd5, 0, 32'hCAFE_0001, saw, ra, wa, rc, ed);
        tick();
        run_load(3'd0, 32'h0000_0A01, 5'd6, 0, 32'hCAFE_0001, saw, ra, wa, rc, ed);
        tests_run++;
        if (!saw || ed != 2 || rsp_data !== 32'h0000_0000 || rsp_rd !== 5'd6) begin
            tests_failed++; $display("FAIL back_to_back: got re=%b edges=%0d d=%h rd=%0d expected 1 2 00000000 6", saw, ed, rsp_data, rsp_rd);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int bad = 0;
        req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h0000_0C00; req_rd = 5'd8;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if (req_ready !== 1'b1 || mem_addr !== 32'h0 || mem_re !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid_wait: got rdy=%b maddr=%h re=%b v=%b expected 1 0 0 0", req_ready, mem_addr, mem_re, rsp_valid);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL late_rvalid_ignored: got %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_half();
        test_errors();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
